// File: rtl/skinny_sbox_ghpc_sequencer.sv
// Sequencer around a gated-clock SKINNY sbox: feeds input shares and fresh randomness,
// tracks the sbox period via Synch and captures the output shares.
module skinny_sbox_ghpc_sequencer #(
    parameter int unsigned LATENCY = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_s0,
    input  logic [3:0]  in_s1,
    input  logic        seed_load,
    input  logic [15:0] seed,
    output logic [3:0]  SI_s0,
    output logic [3:0]  SI_s1,
    output logic [12:0] Fresh,
    input  logic [3:0]  SO_s0,
    input  logic [3:0]  SO_s1,
    input  logic        Synch,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_s0,
    output logic [3:0]  out_s1,
    output logic        err
);

    localparam logic [5:0]  LastCnt  = 6'(LATENCY - 1);
    localparam logic [15:0] LfsrInit = 16'hACE1;

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StBusy,
        StCapt,
        StHold,
        StErr
    } state_e;

    state_e      state;
    logic [5:0]  cnt;
    logic [15:0] lfsr;
    logic        lfsr_fb;
    logic        busy_fault;

    assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    // Synch must coincide exactly with the last counted cycle of the period.
    assign busy_fault = (Synch != (cnt == LastCnt));
    assign Fresh      = (state == StBusy) ? lfsr[12:0] : 13'h0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= StIdle;
            cnt       <= 6'd0;
            lfsr      <= LfsrInit;
            SI_s0     <= 4'h0;
            SI_s1     <= 4'h0;
            out_s0    <= 4'h0;
            out_s1    <= 4'h0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
            err       <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    in_ready <= 1'b1;
                    if (seed_load) begin
                        lfsr <= (seed == 16'h0) ? LfsrInit : seed;
                    end
                    if (in_valid && in_ready) begin
                        SI_s0    <= in_s0;
                        SI_s1    <= in_s1;
                        in_ready <= 1'b0;
                        state    <= StArm;
                    end
                end
                StArm: begin
                    if (Synch) begin
                        cnt   <= 6'd0;
                        state <= StBusy;
                    end
                end
                StBusy: begin
                    lfsr <= {lfsr[14:0], lfsr_fb};
                    cnt  <= cnt + 6'd1;
                    if (busy_fault) begin
                        SI_s0     <= 4'h0;
                        SI_s1     <= 4'h0;
                        out_s0    <= 4'h0;
                        out_s1    <= 4'h0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b0;
                        err       <= 1'b1;
                        state     <= StErr;
                    end else if (Synch) begin
                        state <= StCapt;
                    end
                end
                StCapt: begin
                    out_s0    <= SO_s0;
                    out_s1    <= SO_s1;
                    out_valid <= 1'b1;
                    state     <= StHold;
                end
                StHold: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        SI_s0     <= 4'h0;
                        SI_s1     <= 4'h0;
                        in_ready  <= 1'b1;
                        state     <= StIdle;
                    end
                end
                StErr: begin
                    err <= 1'b1;
                end
                default: begin
                    state <= StErr;
                end
            endcase
        end
    end

endmodule
